// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct-select path and a prescaled
// up/down scan sequencer, plus load, enable, step/wrap strobes and output polarity.
module scan_decoder #(
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned PRESCALE = 4,
   parameter bit          ACT_LOW  = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  en_i,
   input  logic [1:0]            mode_i,
   input  logic                  load_i,
   input  logic [SEL_W-1:0]      d_i,
   output logic [2**SEL_W-1:0]   q_o,
   output logic [SEL_W-1:0]      idx_o,
   output logic                  step_o,
   output logic                  wrap_o
);

   localparam int unsigned OUT_W = 2 ** SEL_W;
   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
   localparam logic [OUT_W-1:0] IDLE = ACT_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
   localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

   logic [SEL_W-1:0] idx_q, idx_d, idx_adv;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] q_q, q_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;
   logic             scan_down;

   // Active bit is flipped against the idle pattern, giving one-hot or one-cold.
   function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] sel);
      logic [OUT_W-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh ^ IDLE;
   endfunction

   assign scan_down = mode_i[0];
   assign idx_adv   = scan_down ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));

   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      q_d    = IDLE;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (en_i) begin
         unique case (mode_i)
            2'b00: begin
               cnt_d = '0;
            end
            2'b01: begin
               idx_d = d_i;
               cnt_d = '0;
               q_d   = dec(d_i);
            end
            2'b10, 2'b11: begin
               if (load_i) begin
                  idx_d = d_i;
                  cnt_d = '0;
                  q_d   = dec(d_i);
               end else if (cnt_q == CNT_MAX) begin
                  idx_d  = idx_adv;
                  cnt_d  = '0;
                  q_d    = dec(idx_adv);
                  step_d = 1'b1;
                  wrap_d = scan_down ? (idx_q == '0) : (idx_q == IDX_MAX);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  q_d   = dec(idx_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         q_q    <= IDLE;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         q_q    <= q_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign q_o    = q_q;
   assign idx_o  = idx_q;
   assign step_o = step_q;
   assign wrap_o = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: three instances (PRESCALE 4 active-high,
// PRESCALE 4 active-low, PRESCALE 1 active-high) share stimulus and a reference model.
module tb_scan_decoder;

   logic       clk;
   logic       reset;
   logic       en;
   logic [1:0] mode;
   logic       load;
   logic [2:0] d;

   logic [7:0] q_w[3];
   logic [2:0] idx_w[3];
   logic       step_w[3];
   logic       wrap_w[3];

   int n_vec = 0;
   int n_err = 0;

   scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACT_LOW(1'b0)) dut_a (
      .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .load_i(load), .d_i(d),
      .q_o(q_w[0]), .idx_o(idx_w[0]), .step_o(step_w[0]), .wrap_o(wrap_w[0])
   );
   scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACT_LOW(1'b1)) dut_b (
      .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .load_i(load), .d_i(d),
      .q_o(q_w[1]), .idx_o(idx_w[1]), .step_o(step_w[1]), .wrap_o(wrap_w[1])
   );
   scan_decoder #(.SEL_W(3), .PRESCALE(1), .ACT_LOW(1'b0)) dut_c (
      .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .load_i(load), .d_i(d),
      .q_o(q_w[2]), .idx_o(idx_w[2]), .step_o(step_w[2]), .wrap_o(wrap_w[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: position, scan ticks elapsed in the current period, outputs.
   int         ps[3]   = '{4, 4, 1};
   bit         alow[3] = '{1'b0, 1'b1, 1'b0};
   int         m_idx[3];
   int         m_ticks[3];
   logic [7:0] m_q[3];
   logic       m_step[3];
   logic       m_wrap[3];

   function automatic logic [7:0] pattern(int k, int pos, bit active);
      logic [7:0] idle;
      idle = alow[k] ? 8'hFF : 8'h00;
      if (!active) return idle;
      return idle ^ 8'(1 << pos);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_idx[k] = 0; m_ticks[k] = 0; m_q[k] = pattern(k, 0, 1'b0);
         m_step[k] = 1'b0; m_wrap[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         bit active;
         active = 1'b0;
         m_step[k] = 1'b0;
         m_wrap[k] = 1'b0;
         if (en) begin
            if (mode == 2'd0) begin
               m_ticks[k] = 0;
            end else if (mode == 2'd1) begin
               m_idx[k] = int'(d); m_ticks[k] = 0; active = 1'b1;
            end else begin
               active = 1'b1;
               if (load) begin
                  m_idx[k] = int'(d); m_ticks[k] = 0;
               end else if (m_ticks[k] + 1 == ps[k]) begin
                  m_ticks[k] = 0;
                  m_step[k] = 1'b1;
                  if (mode == 2'd2) begin
                     m_wrap[k] = (m_idx[k] == 7);
                     m_idx[k] = (m_idx[k] + 1) % 8;
                  end else begin
                     m_wrap[k] = (m_idx[k] == 0);
                     m_idx[k] = (m_idx[k] + 7) % 8;
                  end
               end else begin
                  m_ticks[k]++;
               end
            end
         end
         m_q[k] = pattern(k, m_idx[k], active);
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("model_q[%0d]", k), q_w[k], m_q[k]);
         chk($sformatf("model_idx[%0d]", k), 8'(idx_w[k]), 8'(m_idx[k]));
         chk($sformatf("model_step[%0d]", k), 8'(step_w[k]), 8'(m_step[k]));
         chk($sformatf("model_wrap[%0d]", k), 8'(wrap_w[k]), 8'(m_wrap[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(input logic e, input logic [1:0] m, input logic l, input logic [2:0] dv);
      en = e; mode = m; load = l; d = dv;
   endtask

   // Hand-written expectation for instance k after the next edge.
   task automatic tick_exp(input string name, input int k, input logic [7:0] eq,
                           input logic [2:0] eidx, input logic es, input logic ew);
      tick();
      chk({name, "_q"}, q_w[k], eq);
      chk({name, "_idx"}, 8'(idx_w[k]), 8'(eidx));
      chk({name, "_step"}, 8'(step_w[k]), 8'(es));
      chk({name, "_wrap"}, 8'(wrap_w[k]), 8'(ew));
   endtask

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic [2:0] d;
      logic [7:0] exp_q;
      logic [2:0] exp_idx;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 2'd1, 3'd0, 8'h01, 3'd0};
      tbl[1] = '{1'b1, 2'd1, 3'd1, 8'h02, 3'd1};
      tbl[2] = '{1'b1, 2'd1, 3'd2, 8'h04, 3'd2};
      tbl[3] = '{1'b1, 2'd1, 3'd3, 8'h08, 3'd3};
      tbl[4] = '{1'b1, 2'd1, 3'd4, 8'h10, 3'd4};
      tbl[5] = '{1'b1, 2'd1, 3'd5, 8'h20, 3'd5};
      tbl[6] = '{1'b1, 2'd1, 3'd6, 8'h40, 3'd6};
      tbl[7] = '{1'b1, 2'd1, 3'd7, 8'h80, 3'd7};
      tbl[8] = '{1'b1, 2'd0, 3'd5, 8'h00, 3'd7};
      tbl[9] = '{1'b0, 2'd1, 3'd2, 8'h00, 3'd7};

      reset = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 3'd0);
      model_reset();
      #1;
      chk("reset_q_a", q_w[0], 8'h00);
      chk("reset_q_b", q_w[1], 8'hFF);
      check_model();
      #2 reset = 1'b0;

      // Direct mode table; load is held high to show it is ignored.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].en, tbl[i].mode, 1'b1, tbl[i].d);
         tick_exp($sformatf("table%0d", i), 0, tbl[i].exp_q, tbl[i].exp_idx, 1'b0, 1'b0);
      end

      // Scan up from 6 across the top boundary.
      drive(1'b1, 2'd2, 1'b1, 3'd6);
      tick_exp("up_load", 0, 8'h40, 3'd6, 1'b0, 1'b0);
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick_exp("up_hold6", 0, 8'h40, 3'd6, 1'b0, 1'b0);
      tick_exp("up_step7", 0, 8'h80, 3'd7, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick_exp("up_hold7", 0, 8'h80, 3'd7, 1'b0, 1'b0);
      tick_exp("up_wrap0", 0, 8'h01, 3'd0, 1'b1, 1'b1);

      // Scan down from 1 across the bottom boundary.
      drive(1'b1, 2'd3, 1'b1, 3'd1);
      tick_exp("dn_load", 0, 8'h02, 3'd1, 1'b0, 1'b0);
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick_exp("dn_hold1", 0, 8'h02, 3'd1, 1'b0, 1'b0);
      tick_exp("dn_step0", 0, 8'h01, 3'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick_exp("dn_hold0", 0, 8'h01, 3'd0, 1'b0, 1'b0);
      tick_exp("dn_wrap7", 0, 8'h80, 3'd7, 1'b1, 1'b1);

      // Load on the edge that would otherwise advance.
      drive(1'b1, 2'd2, 1'b1, 3'd1);
      tick();
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      drive(1'b1, 2'd2, 1'b1, 3'd3);
      tick_exp("coll_load", 0, 8'h08, 3'd3, 1'b0, 1'b0);
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick_exp("coll_hold", 0, 8'h08, 3'd3, 1'b0, 1'b0);
      tick_exp("coll_step", 0, 8'h10, 3'd4, 1'b1, 1'b0);

      // Enable drop on the active-low instance keeps idx and the partial count.
      drive(1'b1, 2'd2, 1'b1, 3'd3);
      tick_exp("pol_load", 1, 8'hF7, 3'd3, 1'b0, 1'b0);
      load = 1'b0;
      tick_exp("pol_cnt1", 1, 8'hF7, 3'd3, 1'b0, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) tick_exp("pol_off", 1, 8'hFF, 3'd3, 1'b0, 1'b0);
      en = 1'b1;
      for (int i = 0; i < 2; i++) tick_exp("pol_resume", 1, 8'hF7, 3'd3, 1'b0, 1'b0);
      tick_exp("pol_step", 1, 8'hEF, 3'd4, 1'b1, 1'b0);

      // Asynchronous reset between edges while q=0x20.
      drive(1'b1, 2'd2, 1'b1, 3'd5);
      tick();
      load = 1'b0;
      tick();
      chk("pre_reset_q", q_w[0], 8'h20);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("async_q", q_w[0], 8'h00);
      chk("async_idx", 8'(idx_w[0]), 8'h00);
      chk("async_step", 8'(step_w[0]), 8'h00);
      check_model();
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) tick_exp("rst_hold", 0, 8'h01, 3'd0, 1'b0, 1'b0);
      tick_exp("rst_step", 0, 8'h02, 3'd1, 1'b1, 1'b0);

      // Randomised traffic with occasional mid-cycle resets.
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
               $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
         tick();
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            model_reset();
            #1;
            check_model();
            reset = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer.
- Direct mode: decodes a select input, one cycle of latency.
- Scan mode: auto-steps the active output up or down through all 2^N positions at a programmable rate. Used to drive digit strobes for multiplexed displays and to sweep register-file row selects.
- Adds a load path, an enable, step/wrap strobes and an output-polarity option.

Parameters:
- SEL_W, 3, select width. Output width OUT_W = 2**SEL_W (local, derived).
- PRESCALE, 4, clock cycles per scan step. Legal range is 1 or more; 1 means a step every cycle.
- ACT_LOW, 0, output polarity: 0 = active bit is 1, 1 = active bit is 0 and the rest are 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  block enable.
- mode  input  2  00 off, 01 direct, 10 scan up, 11 scan down.
- load  input  1  in scan modes: load d into the index.
- d  input  SEL_W  select value.
- q  output  OUT_W  registered one-hot (or one-cold) decode.
- idx  output  SEL_W  current index register.
- step  output  1  one-cycle pulse: index advanced by scan this edge.
- wrap  output  1  one-cycle pulse: scan advance crossed the boundary.

Behaviour:
- State: idx (SEL_W bits), prescale counter cnt (0..PRESCALE-1), registered q, registered step and wrap.
- Inactive pattern IDLE is all 0 when ACT_LOW=0 and all 1 when ACT_LOW=1. DEC(i) is bit i active and all other bits inactive.
- Reset, asynchronous and effective immediately, including mid-scan: idx=0, cnt=0, q=IDLE, step=0, wrap=0.
- step and wrap default to 0 on every edge unless set by the scan rules below.
- en=0: idx and cnt hold; q<=IDLE; step=0; wrap=0. Nothing advances.
- en=1, mode 00 (off): idx holds; cnt<=0; q<=IDLE.
- en=1, mode 01 (direct):
  - idx<=d; q<=DEC(d); cnt<=0.
  - Latency is 1 clock from d to q. load is ignored.
- en=1, mode 10/11 (scan), evaluated in priority order:
  1. load=1: idx<=d; cnt<=0; q<=DEC(d); step=0; wrap=0. Load beats a coincident advance.
  2. Otherwise, if cnt==PRESCALE-1: cnt<=0; idx<=idx+1 (up) or idx-1 (down), modulo 2^SEL_W; q<=DEC(new idx); step=1.
     - wrap=1 when up goes from 2^SEL_W-1 to 0, or down goes from 0 to 2^SEL_W-1.
  3. Otherwise: cnt<=cnt+1; q<=DEC(idx).
- Consequences:
  - After entering scan, the first advance occurs PRESCALE edges later.
  - With PRESCALE=1, every edge advances.
  - q always equals DEC(idx) while enabled in a non-off mode.
- Mode change: cnt is cleared on any edge where mode is not scan. Switching between up and down keeps cnt, so the step period is preserved.
- step/wrap are aligned with the q change they describe, not one cycle before it.
- Only one bit of q is ever active. With en=0 or mode=00, no bit is active.
- Widths: cnt is sized to hold PRESCALE-1, with a minimum of 1 bit. There are no other arithmetic widths.

Test Plan:
- Reset, then direct mode at SEL_W=3, ACT_LOW=0:
  - Stimulus: apply reset; en=1, mode=01, drive d=0..7 one per cycle.
  - Required: q is 0x01, 0x02, ... 0x80, each one cycle after d; idx tracks d; step=0 throughout.
- Scan up, PRESCALE=4, starting at idx=6:
  - Required: q=0x40 for 4 cycles, then 0x80, then 0x01.
  - step pulses once per 4 cycles; wrap=1 only on the 0x80 to 0x01 edge.
- Scan down from idx=1:
  - Required: q steps 0x02, 0x01, 0x80.
  - wrap pulses on the 0x01 to 0x80 edge; idx reads 1, 0, 7.
- Load collision, scan up, PRESCALE=4:
  - Stimulus: assert load with d=3 on the edge where cnt==3.
  - Required: q=0x08, step=0, wrap=0. The next advance to 0x10 occurs 4 edges later.
- Enable and polarity, ACT_LOW=1:
  - Stimulus: scanning; drop en for 5 cycles.
  - Required: q=0xFF with idx and cnt frozen. On raising en, scan resumes from the same idx, q=one-cold (for example 0xF7 for idx=3), and the remaining prescale count is honoured.
- Async reset mid-scan:
  - Stimulus: assert reset between clock edges while q=0x20.
  - Required: q=IDLE, idx=0, step=0 immediately, without waiting for a clock edge. After release, scan restarts from 0 with the full PRESCALE wait.
